// File: rtl/keyboard_command_decoder_pkg.sv
// Shared encodings for the PS/2 set-2 keyboard front end: game command codes,
// scan-code constants and the key map used by the decoder.
package keyboard_command_decoder_pkg;

    localparam logic [2:0] CMD_NONE      = 3'd0;
    localparam logic [2:0] CMD_LEFT      = 3'd1;
    localparam logic [2:0] CMD_RIGHT     = 3'd2;
    localparam logic [2:0] CMD_ROTATE    = 3'd3;
    localparam logic [2:0] CMD_SOFT_DROP = 3'd4;
    localparam logic [2:0] CMD_HARD_DROP = 3'd5;
    localparam logic [2:0] CMD_PAUSE     = 3'd6;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_P      = 8'h4D;
    localparam logic [7:0] SC_XLEFT  = 8'h6B;
    localparam logic [7:0] SC_XRIGHT = 8'h74;
    localparam logic [7:0] SC_XUP    = 8'h75;
    localparam logic [7:0] SC_XDOWN  = 8'h72;

    function automatic logic [2:0] mapCode(input logic ext, input logic [7:0] code);
        logic [2:0] c;
        c = CMD_NONE;
        if (ext) begin
            case (code)
                SC_XLEFT:  c = CMD_LEFT;
                SC_XRIGHT: c = CMD_RIGHT;
                SC_XUP:    c = CMD_ROTATE;
                SC_XDOWN:  c = CMD_SOFT_DROP;
                default:   c = CMD_NONE;
            endcase
        end else begin
            case (code)
                SC_A:     c = CMD_LEFT;
                SC_D:     c = CMD_RIGHT;
                SC_W:     c = CMD_ROTATE;
                SC_S:     c = CMD_SOFT_DROP;
                SC_SPACE: c = CMD_HARD_DROP;
                SC_P:     c = CMD_PAUSE;
                default:  c = CMD_NONE;
            endcase
        end
        return c;
    endfunction

    function automatic logic isRepeatable(input logic [2:0] c);
        return (c == CMD_LEFT) || (c == CMD_RIGHT) || (c == CMD_SOFT_DROP);
    endfunction

    // Bit n-1 for command n; CMD_NONE and 7 map to no bit.
    function automatic logic [5:0] cmdOneHot(input logic [2:0] c);
        logic [5:0] oh;
        oh = '0;
        for (int i = 1; i <= 6; i++) begin
            if (c == 3'(i)) oh[i-1] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/keyboard_command_decoder_cmd_fifo.sv
// First-word-fall-through command queue. A push into a full queue is still
// accepted when the head is popped in the same cycle.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr, rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             popEn, pushEn;

    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign popEn    = pop && !empty;
    assign pushEn   = push && (!full || popEn);
    assign headData = empty ? '0 : mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pushEn) begin
                mem[wrPtr[AW-1:0]] <= pushData;
                wrPtr              <= wrPtr + 1'b1;
            end
            if (popEn) rdPtr <= rdPtr + 1'b1;
        end
    end

endmodule

// File: rtl/keyboard_command_decoder.sv
// Turns PS/2 set-2 make/break sequences into Tetrix commands with typematic
// suppression, movement auto-repeat and a small valid/ready command queue.
module keyboard_command_decoder
    import keyboard_command_decoder_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 12_500_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000,
    parameter int          FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_in,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd,
    output logic [5:0] held,
    output logic       overflow
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    logic [7:0]  codePrev;
    logic        newByte;
    logic [1:0]  state, stateNext;
    logic        decMake, decBreak, decExt;
    logic [2:0]  decCmd, trkKey;
    logic [5:0]  decOh, trkOh;
    logic        makeEvt, brkEvt, trkBreak, trkHeld, expire;
    logic [23:0] repCnt;
    logic        pushVld;
    logic [2:0]  pushCmd;
    logic        fifoFull, fifoEmpty;

    assign newByte = (code_in != 8'h00) && (code_in != codePrev);

    always_comb begin
        stateNext = state;
        decMake   = 1'b0;
        decBreak  = 1'b0;
        decExt    = 1'b0;
        if (newByte) begin
            case (state)
                ST_IDLE: begin
                    if (code_in == SC_EXT)      stateNext = ST_EXT;
                    else if (code_in == SC_BRK) stateNext = ST_BRK;
                    else                        decMake   = 1'b1;
                end
                ST_EXT: begin
                    if (code_in == SC_BRK) stateNext = ST_EXT_BRK;
                    else begin
                        decMake   = 1'b1;
                        decExt    = 1'b1;
                        stateNext = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    decBreak  = 1'b1;
                    stateNext = ST_IDLE;
                end
                default: begin
                    decBreak  = 1'b1;
                    decExt    = 1'b1;
                    stateNext = ST_IDLE;
                end
            endcase
        end
    end

    assign decCmd   = mapCode(decExt, code_in);
    assign decOh    = cmdOneHot(decCmd);
    assign trkOh    = cmdOneHot(trkKey);
    assign trkHeld  = (held & trkOh) != 6'd0;
    assign makeEvt  = decMake && (decOh != 6'd0) && ((held & decOh) == 6'd0);
    assign brkEvt   = decBreak && (decOh != 6'd0);
    assign trkBreak = brkEvt && (decCmd == trkKey);
    // A decoder make in the expiry cycle takes the single push slot.
    assign expire   = (repCnt == 24'd1) && trkHeld && !makeEvt && !trkBreak;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            codePrev <= '0;
            held     <= '0;
            repCnt   <= '0;
            trkKey   <= CMD_NONE;
            pushVld  <= 1'b0;
            pushCmd  <= CMD_NONE;
            overflow <= 1'b0;
        end else begin
            state    <= stateNext;
            codePrev <= code_in;

            if (makeEvt)     held <= held | decOh;
            else if (brkEvt) held <= held & ~decOh;

            // Counter value 0 means idle; reaching 1 is the expiry point.
            if (makeEvt && isRepeatable(decCmd)) begin
                repCnt <= 24'(REPEAT_DELAY);
                trkKey <= decCmd;
            end else if (trkBreak) begin
                repCnt <= '0;
            end else if (expire || (makeEvt && repCnt == 24'd1 && trkHeld)) begin
                repCnt <= 24'(REPEAT_PERIOD);
            end else if (repCnt != 24'd0) begin
                repCnt <= repCnt - 24'd1;
            end

            pushVld  <= makeEvt || expire;
            pushCmd  <= makeEvt ? decCmd : trkKey;
            overflow <= pushVld && fifoFull && !(cmd_ready && !fifoEmpty);
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pushVld),
        .pushData (pushCmd),
        .pop      (cmd_ready),
        .headData (cmd),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign cmd_valid = !fifoEmpty;

endmodule

// File: doc/keyboard_command_decoder.md
# keyboard_command_decoder

Consumes the 8-bit scan-code level produced by the PS/2 keyboard frame receiver and turns PS/2 set-2 make/break sequences into Tetrix game commands. Handles E0 extended and F0 break prefixes, suppresses keyboard typematic repeats, and generates its own auto-repeat for movement keys. Queues commands in a small FIFO with a valid/ready handshake toward the game-logic controller.

## Interface
- REPEAT_DELAY, 12_500_000: clk cycles a repeatable key is held before the first auto-repeat (250 ms at 50 MHz).
- REPEAT_PERIOD, 5_000_000: clk cycles between subsequent auto-repeats (100 ms).
- FIFO_DEPTH, 4: command queue entries; power of two, ≥2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- code_in  in  8  scan-code level from the frame receiver; 0 = no valid frame.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_ready  in  1  consumer accepts the head this cycle.
- cmd  out  3  head command: 1 LEFT, 2 RIGHT, 3 ROTATE, 4 SOFT_DROP, 5 HARD_DROP, 6 PAUSE. 0 and 7 are never emitted.
- held  out  6  level per command (bit n-1 = command n), set on make, cleared on break.
- overflow  out  1  one-cycle pulse when a command is dropped because the FIFO is full.

## Operation
- Byte detect: register code_in into code_prev every cycle. new_byte = (code_in != 0) && (code_in != code_prev).
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 then F0).
  - IDLE: E0 → EXT; F0 → BRK; any other byte → normal make, stay IDLE.
  - EXT: F0 → EXT_BRK; other byte → extended make → IDLE.
  - BRK: byte → normal break → IDLE.
  - EXT_BRK: byte → extended break → IDLE.
- Key map. Normal codes: 1C/23/1D/1B = A/D/W/S = LEFT/RIGHT/ROTATE/SOFT_DROP; 29 = space = HARD_DROP; 4D = P = PAUSE. Extended codes: 6B/74/75/72 = LEFT/RIGHT/ROTATE/SOFT_DROP. Unmapped codes, including E1, are ignored; the FSM still returns to IDLE.
- Make of command c with held[c] = 0: set held[c] and enqueue c. Make with held[c] = 1 is a typematic repeat: ignore it.
- Break of c: clear held[c]. Never enqueues. A break of a key not held is a no-op.
- Auto-repeat applies to LEFT, RIGHT and SOFT_DROP only.
  - One 24-bit counter tracks the most recent repeatable make. That make loads the counter with REPEAT_DELAY.
  - When the counter reaches 0 while that key is still held: enqueue the key again and reload with REPEAT_PERIOD.
  - A break of the tracked key stops the counter.
- FIFO: push when a command is generated, pop on cmd_valid && cmd_ready.
  - Push while full without a same-cycle pop: drop the command, pulse overflow.
  - Push while full with a same-cycle pop: accept the push.
  - Pop while empty: no effect.
  - Pointer width is log2(FIFO_DEPTH)+1; pointers wrap naturally.

## Timing
- Reset (asynchronous assert, synchronous release): FSM → IDLE; code_prev, held, counter, FIFO pointers → 0; cmd_valid = 0, cmd = 0, overflow = 0.
- Reset mid-sequence (for example after E0): the prefix is lost. The next byte is decoded from IDLE.
- Latency: decode registers at edge k, where k is the first edge sampling a new byte. cmd_valid is asserted after edge k+1. The FIFO is first-word-fall-through; cmd is valid whenever cmd_valid = 1.
- Simultaneous decoder make and auto-repeat expiry in one cycle: the decoder event wins, the expiry is discarded, and the counter reloads per the new make.
- cmd and cmd_valid hold stable until accepted. Throughput is one command per cycle.

## Structure
- Shared package holds the command encodings (CMD_LEFT … CMD_PAUSE) and the scan-code constants (E0, F0, and each mapped make code).
- Sub-module cmd_fifo: parameterised synchronous FIFO, width 3, with full/empty and the push-while-full-with-pop rule. The decoder FSM, held vector and repeat counter stay in the top module.

## Test plan
- Sequence 1C, F0, 1C with cmd_ready = 1 → exactly one LEFT. held[0] reads 1 between the make and the break, then 0.
- Sequence E0, 75, E0, F0, 75 → one ROTATE. The FSM passes through EXT and EXT_BRK and ends in IDLE.
- 23 presented three times, each separated by code_in = 0, with no break → one RIGHT only (typematic suppressed).
- With REPEAT_DELAY = 10 and REPEAT_PERIOD = 4, hold 1B for 30 cycles then release → SOFT_DROP at make, +10, +14, +18, +22, +26 cycles (±1, per latency); none after the break.
- cmd_ready = 0 and six distinct makes with FIFO_DEPTH = 4 → four queued in order, two overflow pulses. Then pop with cmd_ready = 1 for one cycle while pushing a make → the push is accepted.
- Assert rst after a lone E0, release, send 6B → normal-code interpretation: ignored (6B unmapped when not extended), no command emitted.
